// File: rtl/qpsk_frame_ctrl_if.sv
// Handshake bundle between the frame scheduler, its upstream byte source and the QPSK mapper.
interface qpsk_frame_ctrl_if;
    logic       start;
    logic [7:0] len;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       busy;
    logic       done;

    modport master (
        output start, len, byte_valid, byte_data,
        input  byte_ready, sym_valid, sym_data, busy, done
    );

    modport slave (
        input  start, len, byte_valid, byte_data,
        output byte_ready, sym_valid, sym_data, busy, done
    );
endinterface

// File: rtl/qpsk_frame_ctrl.sv
// Frame scheduler for the QPSK mapper: preamble, length header, payload, then an idle gap,
// serialized as one 2-bit symbol per clock.
module qpsk_frame_ctrl #(
    parameter int PRE_LEN = 16,
    parameter int GAP_LEN = 4
) (
    input logic              CLK,
    input logic              RST,
    qpsk_frame_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, GAP} state_e;

    localparam logic [15:0] PRE_N = 16'(PRE_LEN);
    localparam logic [15:0] GAP_N = 16'(GAP_LEN);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  bytes_left_q;
    logic [5:0]  sh_q;
    logic [1:0]  pairs_q;
    logic        sym_valid_q;
    logic [1:0]  sym_data_q;
    logic        busy_q;
    logic        done_q;
    logic        byte_ready;

    // Decoded from state only so the upstream source never sees a combinational path from byte_valid.
    assign byte_ready = (state_q == PAY) && (pairs_q == 2'd0) && (bytes_left_q != 8'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bytes_left_q <= '0;
            sh_q         <= '0;
            pairs_q      <= '0;
            sym_valid_q  <= 1'b0;
            sym_data_q   <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sym_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    if (bus.start) begin
                        state_q      <= PRE;
                        bytes_left_q <= bus.len;
                        cnt_q        <= 16'd1;
                        sym_valid_q  <= 1'b1;
                        sym_data_q   <= 2'b00;
                        busy_q       <= 1'b1;
                    end
                end
                PRE: begin
                    sym_valid_q <= 1'b1;
                    if (cnt_q == PRE_N) begin
                        // bytes_left_q still holds the captured length here
                        sym_data_q <= bytes_left_q[7:6];
                        sh_q       <= bytes_left_q[5:0];
                        cnt_q      <= 16'd1;
                        state_q    <= HDR;
                    end else begin
                        sym_data_q <= {2{cnt_q[0]}};
                        cnt_q      <= cnt_q + 16'd1;
                    end
                end
                HDR: begin
                    sym_valid_q <= 1'b1;
                    sym_data_q  <= sh_q[5:4];
                    sh_q        <= {sh_q[3:0], 2'b00};
                    if (cnt_q == 16'd3) begin
                        cnt_q   <= '0;
                        pairs_q <= '0;
                        state_q <= (bytes_left_q != 8'd0) ? PAY : GAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                PAY: begin
                    if (pairs_q != 2'd0) begin
                        sym_valid_q <= 1'b1;
                        sym_data_q  <= sh_q[5:4];
                        sh_q        <= {sh_q[3:0], 2'b00};
                        pairs_q     <= pairs_q - 2'd1;
                        if (pairs_q == 2'd1 && bytes_left_q == 8'd0) begin
                            state_q <= GAP;
                            cnt_q   <= '0;
                        end
                    end else if (byte_ready && bus.byte_valid) begin
                        sym_valid_q  <= 1'b1;
                        sym_data_q   <= bus.byte_data[7:6];
                        sh_q         <= bus.byte_data[5:0];
                        pairs_q      <= 2'd3;
                        bytes_left_q <= bytes_left_q - 8'd1;
                    end else begin
                        sym_valid_q <= 1'b0;
                    end
                end
                GAP: begin
                    sym_valid_q <= 1'b0;
                    // done is registered one edge early so it lines up with the last low cycle
                    if (cnt_q == GAP_N) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        done_q <= (cnt_q == GAP_N - 16'd1);
                        cnt_q  <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.sym_valid  = sym_valid_q;
    assign bus.sym_data   = sym_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// Directed bench for qpsk_frame_ctrl: frame contents, bubbles, ignored starts, resets.
module tb_qpsk_frame_ctrl;
    localparam int PRE_LEN = 16;
    localparam int GAP_LEN = 4;

    logic CLK = 1'b0;
    logic RST;

    qpsk_frame_ctrl_if bus();

    qpsk_frame_ctrl #(.PRE_LEN(PRE_LEN), .GAP_LEN(GAP_LEN)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [7:0] pay    [256];
    int         stalls [256];
    logic [1:0] got_q  [$];
    logic       trace_q[$];
    int         hs_n, rdy_n, done_n, first_bubble;

    logic [1:0] ref28 [28] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3,
                               2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3,
                               2'd0, 2'd0, 2'd0, 2'd2,
                               2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sym_valid"},  32'(bus.sym_valid),  0);
        chk({tag, "_sym_data"},   32'(bus.sym_data),   0);
        chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 0);
        chk({tag, "_busy"},       32'(bus.busy),       0);
        chk({tag, "_done"},       32'(bus.done),       0);
    endtask

    task automatic chk_ref28(input string tag);
        int mism = 0;
        for (int i = 0; i < 28; i++)
            if (i >= got_q.size() || got_q[i] !== ref28[i]) mism++;
        chk({tag, "_ref_symbols"}, 32'(mism), 0);
    endtask

    task automatic run_frame(input string nm, input int L, input bit pulse, input bit hold);
        int         idx = 0;
        int         stall_left;
        int         cyc = 0;
        int         tot_stalls = 0;
        int         mism = 0;
        int         zeros = 0;
        int         tail = 0;
        bit         fin = 0;
        logic [7:0] lb;
        logic [7:0] b;
        logic [1:0] e_q[$];

        got_q.delete();
        trace_q.delete();
        hs_n = 0; rdy_n = 0; done_n = 0; first_bubble = -1;
        lb = L[7:0];
        for (int k = 0; k < L; k++) tot_stalls += stalls[k];
        stall_left = (L > 0) ? stalls[0] : 0;

        bus.start = 1'b1; bus.len = lb; bus.byte_valid = 1'b1; bus.byte_data = pay[0];
        tick();
        chk({nm, "_first_cycle"}, 32'({bus.sym_valid, bus.busy, bus.sym_data}), 32'b1100);
        bus.start = hold;

        while (!fin && cyc < 3000) begin
            trace_q.push_back(bus.sym_valid);
            if (bus.sym_valid) got_q.push_back(bus.sym_data);
            else if (first_bubble < 0) first_bubble = got_q.size();
            if (bus.done) begin
                done_n++;
                chk({nm, "_busy_at_done"}, 32'(bus.busy), 1);
                fin = 1;
            end
            if (bus.byte_ready) rdy_n++;
            if (bus.byte_ready && stall_left > 0) begin
                bus.byte_valid = 1'b0;
                stall_left--;
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = pay[idx];
            end
            if (bus.byte_ready && bus.byte_valid) begin
                hs_n++;
                idx++;
                stall_left = (idx < L) ? stalls[idx] : 0;
            end
            if (pulse) bus.start = (cyc == 3) || (cyc == 30) || (bus.busy && !bus.sym_valid);
            else       bus.start = hold;
            tick();
            cyc++;
        end
        chk({nm, "_done_seen"}, 32'(fin), 1);
        chk({nm, "_busy_after"}, 32'({bus.busy, bus.done, bus.sym_valid}), 0);

        if (hold) begin
            tick();
            chk({nm, "_restart"}, 32'({bus.sym_valid, bus.busy, bus.sym_data}), 32'b1100);
        end else begin
            bus.start = 1'b0;
            tick();
            chk({nm, "_stays_idle"}, 32'({bus.busy, bus.sym_valid}), 0);
        end

        for (int i = 0; i < PRE_LEN; i++) e_q.push_back((i % 2) ? 2'b11 : 2'b00);
        e_q.push_back(lb[7:6]); e_q.push_back(lb[5:4]); e_q.push_back(lb[3:2]); e_q.push_back(lb[1:0]);
        for (int k = 0; k < L; k++) begin
            b = pay[k];
            e_q.push_back(b[7:6]); e_q.push_back(b[5:4]); e_q.push_back(b[3:2]); e_q.push_back(b[1:0]);
        end
        for (int i = 0; i < e_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== e_q[i]) mism++;

        foreach (trace_q[i]) if (!trace_q[i]) zeros++;
        for (int k = trace_q.size() - 1; k >= 0 && !trace_q[k]; k--) tail++;

        chk({nm, "_sym_count"},  32'(got_q.size()), 32'(PRE_LEN + 4 + 4 * L));
        chk({nm, "_sym_errors"}, 32'(mism), 0);
        chk({nm, "_handshakes"}, 32'(hs_n), 32'(L));
        chk({nm, "_ready_cyc"},  32'(rdy_n), 32'(L + tot_stalls));
        chk({nm, "_gap_low"},    32'(tail), 32'(GAP_LEN));
        chk({nm, "_bubbles"},    32'(zeros - tail), 32'(tot_stalls));
        chk({nm, "_done_count"}, 32'(done_n), 1);
    endtask

    initial begin
        RST = 1'b1;
        bus.start = 1'b0; bus.len = 8'h00; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
        foreach (stalls[k]) stalls[k] = 0;
        foreach (pay[k]) pay[k] = 8'h00;

        for (int i = 0; i < 2; i++) begin
            bus.start = ~bus.start; bus.byte_valid = ~bus.byte_valid;
            bus.len = 8'hA5; bus.byte_data = 8'h5A;
            tick();
            chk_idle("reset");
        end
        RST = 1'b0; bus.start = 1'b0; bus.byte_valid = 1'b0;
        tick();
        chk_idle("post_reset");

        run_frame("len0", 0, 1'b0, 1'b0);

        pay[0] = 8'hB4; pay[1] = 8'h1E;
        run_frame("len2", 2, 1'b0, 1'b0);
        chk_ref28("len2");

        stalls[1] = 3;
        run_frame("stall3", 2, 1'b0, 1'b0);
        chk_ref28("stall3");
        chk("stall3_bubble_pos", 32'(first_bubble), 24);
        stalls[1] = 0;

        pay[0] = 8'h3C; pay[1] = 8'hC3; pay[2] = 8'h99;
        run_frame("pulse", 3, 1'b1, 1'b0);

        for (int k = 0; k < 255; k++) begin
            pay[k]    = 8'($urandom);
            stalls[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        end
        run_frame("len255", 255, 1'b0, 1'b0);
        foreach (stalls[k]) stalls[k] = 0;

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        bus.start = 1'b1; bus.len = 8'd4; bus.byte_valid = 1'b1; bus.byte_data = 8'h11;
        tick();
        bus.start = 1'b0;
        repeat (24) tick();
        chk("midrst_in_payload", 32'({bus.busy, bus.sym_valid}), 32'b11);
        RST = 1'b1;
        tick();
        chk_idle("midrst");
        RST = 1'b0;
        pay[0] = 8'hE7;
        run_frame("after_rst", 1, 1'b0, 1'b0);

        run_frame("hold", 0, 1'b0, 1'b1);
        bus.start = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        chk_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
